// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: data width default, Q7.8 format constants,
// clog2 helper and the tag pipe entry type.
package cordic_pkg;

  localparam int CORDIC_DATA_WIDTH = 16;
  localparam int Q_INT_BITS        = 7;
  localparam int Q_FRAC_BITS       = 8;
  localparam logic signed [15:0] Q_ONE = 16'sh0100;

  // Widest requester ID needed for up to 8 requesters.
  localparam int TAG_ID_W = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// NUM_REQ-wide grant with rotating priority pointer.
// Build with CORDIC_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority.
module cordic_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               fire_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

`ifdef CORDIC_ARB_FIXED_PRIORITY_EN
  logic unused_rr;
  assign unused_rr = clk ^ rst_n ^ fire_i;

  // Scan high to low so the lowest requesting index is written last.
  always_comb begin
    logic [IDX_W-1:0] ii;
    gnt_o     = '0;
    gnt_idx_o = '0;
    ii        = '0;
    if (en_i) begin
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        ii = IDX_W'(i);
        if (req_i[ii]) begin
          gnt_o     = '0;
          gnt_o[ii] = 1'b1;
          gnt_idx_o = ii;
        end
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // ptr_q is the highest-priority index; scan ptr+N-1 down to ptr so
  // the request closest to the pointer is written last.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    gnt_o     = '0;
    gnt_idx_o = '0;
    j         = 0;
    jj        = '0;
    if (en_i) begin
      for (int k = NUM_REQ-1; k >= 0; k--) begin
        j = int'(ptr_q) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        jj = IDX_W'(j);
        if (req_i[jj]) begin
          gnt_o     = '0;
          gnt_o[jj] = 1'b1;
          gnt_idx_o = jj;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire_i)
      ptr_d = (int'(gnt_idx_o) == NUM_REQ-1) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/cordic_req_arbiter.sv
// Shares one fixed-latency CORDIC pipeline between NUM_REQ requesters and
// routes results back by tag. CORDIC_ARB_FIXED_PRIORITY_EN selects fixed priority.
module cordic_req_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = CORDIC_DATA_WIDTH,
  parameter int PIPE_LATENCY = 8,
  parameter int MAX_INFLIGHT = 8,
  parameter int TAG_WIDTH    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ),
  localparam int CNT_W       = clog2(MAX_INFLIGHT + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_degree,
  input  logic [NUM_REQ-1:0]            req_arctan_en,
  output logic                          core_valid_in,
  output logic [DATA_WIDTH-1:0]         core_x_in,
  output logic [DATA_WIDTH-1:0]         core_y_in,
  output logic [DATA_WIDTH-1:0]         core_degree_in,
  output logic                          core_arctan_en_in,
  input  logic                          core_valid_out,
  input  logic [DATA_WIDTH-1:0]         core_x_out,
  input  logic [DATA_WIDTH-1:0]         core_y_out,
  input  logic [DATA_WIDTH-1:0]         core_degree_out,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_x,
  output logic [DATA_WIDTH-1:0]         rsp_y,
  output logic [DATA_WIDTH-1:0]         rsp_degree,
  output logic [CNT_W-1:0]              inflight,
  output logic                          err_orphan
);

  logic [NUM_REQ-1:0]    gnt;
  logic [TAG_WIDTH-1:0]  gnt_idx;
  logic                  can_issue, fire;
  logic [DATA_WIDTH-1:0] x_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] y_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] d_a [NUM_REQ];

  logic                  cv_q;
  logic [DATA_WIDTH-1:0] cx_q, cy_q, cd_q;
  logic                  ca_q;
  tag_t                  tag_q [PIPE_LATENCY+1];
  tag_t                  tail, tag_in;
  logic                  ret, orphan;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rx_q, ry_q, rd_q;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic                  err_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign x_a[i] = req_x[i*DATA_WIDTH +: DATA_WIDTH];
    assign y_a[i] = req_y[i*DATA_WIDTH +: DATA_WIDTH];
    assign d_a[i] = req_degree[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign can_issue = (inflight_q < CNT_W'(MAX_INFLIGHT));
  assign fire      = |(gnt & req_valid);
  assign req_ready = gnt;

  cordic_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_WIDTH)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (can_issue),
    .req_i     (req_valid),
    .fire_i    (fire),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    tag_in       = '0;
    tag_in.valid = fire;
    if (fire) tag_in.id[TAG_WIDTH-1:0] = gnt_idx;
  end

  // The tail lines up with the core's valid_out for the same operation.
  assign tail   = tag_q[PIPE_LATENCY];
  assign ret    = core_valid_out && tail.valid;
  assign orphan = core_valid_out ^ tail.valid;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid_d[i] = ret && (tail.id == TAG_ID_W'(i));
  end

  always_comb begin
    logic inc, dec;
    inc        = fire && (inflight_q != CNT_W'(MAX_INFLIGHT));
    dec        = (|rsp_valid_q) && (inflight_q != '0);
    inflight_d = inflight_q;
    if (inc && !dec)      inflight_d = inflight_q + 1'b1;
    else if (dec && !inc) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q        <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      cd_q        <= '0;
      ca_q        <= 1'b0;
      for (int i = 0; i <= PIPE_LATENCY; i++) tag_q[i] <= '0;
      rsp_valid_q <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      rd_q        <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cv_q <= fire;
      if (fire) begin
        cx_q <= x_a[gnt_idx];
        cy_q <= y_a[gnt_idx];
        cd_q <= d_a[gnt_idx];
        ca_q <= req_arctan_en[gnt_idx];
      end
      tag_q[0] <= tag_in;
      for (int i = 1; i <= PIPE_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid_q <= rsp_valid_d;
      if (ret) begin
        rx_q <= core_x_out;
        ry_q <= core_y_out;
        rd_q <= core_degree_out;
      end
      inflight_q <= inflight_d;
      err_q      <= err_q | orphan;
    end
  end

  assign core_valid_in     = cv_q;
  assign core_x_in         = cx_q;
  assign core_y_in         = cy_q;
  assign core_degree_in    = cd_q;
  assign core_arctan_en_in = ca_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_x             = rx_q;
  assign rsp_y             = ry_q;
  assign rsp_degree        = rd_q;
  assign inflight          = inflight_q;
  assign err_orphan        = err_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter with a fixed-latency core model
// (x+0x11, y+0x22, degree-0x100). Honors CORDIC_ARB_FIXED_PRIORITY_EN.
module tb_cordic_req_arbiter;
  localparam int NR = 2;
  localparam int DW = 16;
  localparam int PL = 8;
  localparam int MI = 4;
  localparam int CW = 3;

  logic            clk, rst_n;
  logic [NR-1:0]   req_valid, req_ready, req_arctan_en, rsp_valid;
  logic [NR*DW-1:0] req_x, req_y, req_degree;
  logic            core_valid_in, core_arctan_en_in, core_valid_out, force_cvo;
  logic [DW-1:0]   core_x_in, core_y_in, core_degree_in;
  logic [DW-1:0]   core_x_out, core_y_out, core_degree_out;
  logic [DW-1:0]   rsp_x, rsp_y, rsp_degree;
  logic [CW-1:0]   inflight;
  logic            err_orphan;

  int n_assert = 0;
  int n_fail   = 0;

  cordic_req_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .PIPE_LATENCY(PL), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_degree(req_degree),
    .req_arctan_en(req_arctan_en),
    .core_valid_in(core_valid_in), .core_x_in(core_x_in), .core_y_in(core_y_in),
    .core_degree_in(core_degree_in), .core_arctan_en_in(core_arctan_en_in),
    .core_valid_out(core_valid_out), .core_x_out(core_x_out),
    .core_y_out(core_y_out), .core_degree_out(core_degree_out),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_degree(rsp_degree),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: PL-cycle delay line with a simple data transform.
  logic [PL-1:0] m_v;
  logic [DW-1:0] m_x [PL];
  logic [DW-1:0] m_y [PL];
  logic [DW-1:0] m_d [PL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_v <= '0;
    else        m_v <= {m_v[PL-2:0], core_valid_in};
  end

  always_ff @(posedge clk) begin
    m_x[0] <= core_x_in + 16'h0011;
    m_y[0] <= core_y_in + 16'h0022;
    m_d[0] <= core_degree_in - 16'h0100;
    for (int i = 1; i < PL; i++) begin
      m_x[i] <= m_x[i-1];
      m_y[i] <= m_y[i-1];
      m_d[i] <= m_d[i-1];
    end
  end

  assign core_valid_out  = m_v[PL-1] | force_cvo;
  assign core_x_out      = m_x[PL-1];
  assign core_y_out      = m_y[PL-1];
  assign core_degree_out = m_d[PL-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [NR-1:0] pat [4];
  logic [DW-1:0] last_x;
  logic          last_a;
  logic          seen;

  initial begin
`ifdef CORDIC_ARB_FIXED_PRIORITY_EN
    pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b01; pat[3] = 2'b01;
    last_x = 16'h0010; last_a = 1'b0;
`else
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
    last_x = 16'h0020; last_a = 1'b1;
`endif
    rst_n = 1'b1; force_cvo = 1'b0;
    req_valid = '0; req_x = '0; req_y = '0; req_degree = '0; req_arctan_en = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_core_valid", 32'(core_valid_in), 32'd0);
    check("rst_core_x", 32'(core_x_in), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_err", 32'(err_orphan), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Contention: both requesters held for four cycles.
    req_x = {16'h0020, 16'h0010};
    req_y = {16'h0002, 16'h0001};
    req_degree = {16'h0400, 16'h0300};
    req_arctan_en = 2'b10;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("cont_ready%0d", k), 32'(req_ready), 32'(pat[k]));
      tick(1);
    end
    req_valid = '0;
    check("cont_inflight_peak", 32'(inflight), 32'd4);
    check("cont_core_x_last", 32'(core_x_in), 32'(last_x));
    check("cont_core_arctan", 32'(core_arctan_en_in), 32'(last_a));
    tick(5);
    check("cont_rsp_early", 32'(rsp_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check($sformatf("cont_rsp%0d", k), 32'(rsp_valid), 32'(pat[k]));
      check($sformatf("cont_rsp_x%0d", k), 32'(rsp_x),
            (pat[k] == 2'b01) ? 32'h0021 : 32'h0031);
    end
    tick(1);
    check("cont_drained", 32'(inflight), 32'd0);

    // Single issue from requester 0.
    req_x = {16'h0020, 16'h0100};
    req_y = '0;
    req_degree = {16'h0400, 16'h1E00};
    req_arctan_en = 2'b00;
    req_valid = 2'b01;
    #1 check("single_ready", 32'(req_ready), 32'd1);
    tick(1);
    req_valid = '0;
    check("single_cvalid", 32'(core_valid_in), 32'd1);
    check("single_cx", 32'(core_x_in), 32'h0100);
    check("single_cdeg", 32'(core_degree_in), 32'h1E00);
    check("single_carctan", 32'(core_arctan_en_in), 32'd0);
    check("single_inflight1", 32'(inflight), 32'd1);
    tick(1);
    check("single_cvalid_low", 32'(core_valid_in), 32'd0);
    check("single_cx_hold", 32'(core_x_in), 32'h0100);
    tick(7);
    check("single_rsp_early", 32'(rsp_valid), 32'd0);
    tick(1);
    check("single_rsp", 32'(rsp_valid), 32'd1);
    check("single_rsp_x", 32'(rsp_x), 32'h0111);
    check("single_rsp_y", 32'(rsp_y), 32'h0022);
    check("single_rsp_deg", 32'(rsp_degree), 32'h1D00);
    tick(1);
    check("single_inflight0", 32'(inflight), 32'd0);
    check("single_rsp_done", 32'(rsp_valid), 32'd0);

    // Credit limit: requester 0 held continuously.
    req_valid = 2'b01;
    #1 check("credit_ready0", 32'(req_ready), 32'd1);
    tick(4);
    check("credit_peak", 32'(inflight), 32'd4);
    check("credit_blocked", 32'(req_ready), 32'd0);
    tick(6);
    check("credit_rsp_first", 32'(rsp_valid), 32'd1);
    check("credit_blocked_at_rsp", 32'(req_ready), 32'd0);
    check("credit_still_full", 32'(inflight), 32'd4);
    tick(1);
    check("credit_freed", 32'(inflight), 32'd3);
    check("credit_ready_again", 32'(req_ready), 32'd1);
    tick(1);
    check("credit_fire_and_rsp", 32'(inflight), 32'd3);
    tick(3);
    check("credit_refull", 32'(inflight), 32'd4);
    check("credit_reblocked", 32'(req_ready), 32'd0);
    req_valid = '0;
    tick(12);
    check("credit_drained", 32'(inflight), 32'd0);

    // Orphan: core output with an empty tag pipe.
    force_cvo = 1'b1;
    #1 check("orphan_before", 32'(err_orphan), 32'd0);
    tick(1);
    force_cvo = 1'b0;
    check("orphan_set", 32'(err_orphan), 32'd1);
    check("orphan_no_rsp", 32'(rsp_valid), 32'd0);
    tick(3);
    check("orphan_sticky", 32'(err_orphan), 32'd1);
    check("orphan_no_rsp_later", 32'(rsp_valid), 32'd0);

    // Reset with three operations in flight.
    req_valid = 2'b01;
    tick(3);
    req_valid = '0;
    check("midrst_inflight3", 32'(inflight), 32'd3);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("midrst_inflight", 32'(inflight), 32'd0);
    check("midrst_err", 32'(err_orphan), 32'd0);
    check("midrst_core_x", 32'(core_x_in), 32'd0);
    check("midrst_rsp_x", 32'(rsp_x), 32'd0);
    check("midrst_core_valid", 32'(core_valid_in), 32'd0);
    tick(1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      seen = seen | (|rsp_valid);
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_no_orphan", 32'(err_orphan), 32'd0);
    check("midrst_inflight_end", 32'(inflight), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
